// File: rtl/uart_pkg.sv
// Shared definitions for the matrix UART transmitter and receiver:
// action codes, parity modes and the transmit FSM state encoding.
package uart_pkg;

    localparam logic [3:0] ACT_WRITE = 4'd1;
    localparam logic [3:0] ACT_SEND  = 4'd2;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Any mode other than even is treated as odd.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PAR_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_transmitter_baud_tick.sv
// DIV-cycle bit-period counter with clear/enable and a one-cycle tick
// on the last count of each period; shared with the receiver.
module uart_baud_tick #(
    parameter int DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// Matrix cell store plus UART frame serialiser (start, data LSB-first,
// optional parity, stop). UART_TX_TWO_STOP_EN selects two stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int W   = 8,
    parameter int DIV = 3,
    parameter int PAR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         row,
    input  logic [1:0]   col,
    input  logic [3:0]   action,
    input  logic [W-1:0] w_data,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] t_cell
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;

    tx_state_t      state;
    tx_state_t      state_nx;
    logic [W-1:0]   cells [2][4];
    logic [W-1:0]   shreg;
    logic           par_reg;
    logic [BW-1:0]  bit_cnt;
    logic           bit_last;
    logic           stop_last;
    logic           send_ok;
    logic           tick;

    assign t_cell   = cells[row][col];
    assign busy     = (state != ST_IDLE);
    assign send_ok  = (action == ACT_SEND) && (state == ST_IDLE);
    assign bit_last = (bit_cnt == BW'(W - 1));

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (~busy),
        .enable(busy),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 4; c++) begin
                    cells[r][c] <= '0;
                end
            end
        end else if (action == ACT_WRITE) begin
            cells[row][col] <= w_data;
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt;

    assign stop_last = stop_cnt;

    always_ff @(posedge clk) begin
        if (rst || send_ok) begin
            stop_cnt <= 1'b0;
        end else if (tick && state == ST_STOP) begin
            stop_cnt <= ~stop_cnt;
        end
    end
`else
    assign stop_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (send_ok) state_nx = ST_START;
            end
            ST_START: begin
                if (tick) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (tick && bit_last)
                    state_nx = (PAR == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                if (tick) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (tick && stop_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shreg[0];
            ST_PARITY: tx = par_reg;
            default:   tx = 1'b1;
        endcase
    end

    // Snapshot on accept: later writes to the cell leave the frame intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            par_reg <= 1'b0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == ST_STOP) && tick && stop_last;
            if (send_ok) begin
                shreg   <= cells[row][col];
                par_reg <= parity_bit(^cells[row][col], PAR);
                bit_cnt <= '0;
            end else if (tick && state == ST_DATA) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: three transmitter configurations driven in lockstep,
// frames decoded from tx/busy/done and compared with a reference model.
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int N = 3;
    localparam int DIVS [N] = '{3, 1, 2};
    localparam int PARS [N] = '{0, 1, 2};
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOPS = 2;
`else
    localparam int STOPS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       row = 1'b0;
    logic [1:0] col = 2'd0;
    logic [3:0] action = 4'd0;
    logic [7:0] w_data = 8'd0;

    logic       tx_w   [N];
    logic       busy_w [N];
    logic       done_w [N];
    logic [7:0] tc_w   [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] mcell [2][4];
    int         free_at [N];
    logic [7:0] exp_q [N][$];

    logic [63:0] cap [N];
    int          cap_len [N];
    bit          prev_rst = 1'b0;

    always #5 clk = ~clk;

    uart_transmitter #(.W(8), .DIV(3), .PAR(0)) d0 (
        .clk(clk), .rst(rst), .row(row), .col(col), .action(action),
        .w_data(w_data), .tx(tx_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .t_cell(tc_w[0]));

    uart_transmitter #(.W(8), .DIV(1), .PAR(1)) d1 (
        .clk(clk), .rst(rst), .row(row), .col(col), .action(action),
        .w_data(w_data), .tx(tx_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .t_cell(tc_w[1]));

    uart_transmitter #(.W(8), .DIV(2), .PAR(2)) d2 (
        .clk(clk), .rst(rst), .row(row), .col(col), .action(action),
        .w_data(w_data), .tx(tx_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .t_cell(tc_w[2]));

    function automatic int flen(input int k);
        return DIVS[k] * (1 + 8 + ((PARS[k] != 0) ? 1 : 0) + STOPS);
    endfunction

    // Expected tx samples: frame bits, each repeated DIV times.
    function automatic void build(input int k, input logic [7:0] d,
                                  output int len, output logic [63:0] v);
        bit q[$];
        bit odd;
        odd = ($countones(d) % 2) == 1;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (PARS[k] == 1) q.push_back(odd);
        else if (PARS[k] != 0) q.push_back(!odd);
        for (int i = 0; i < STOPS; i++) q.push_back(1'b1);
        v = '0;
        len = 0;
        foreach (q[i]) begin
            for (int j = 0; j < DIVS[k]; j++) begin
                v[len] = q[i];
                len++;
            end
        end
    endfunction

    task automatic check_frame(input int k);
        logic [7:0]  d;
        logic [63:0] v;
        int          len;
        checks++;
        if (exp_q[k].size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected dut%0d got done with len=%0d required no frame",
                     k, cap_len[k]);
            return;
        end
        d = exp_q[k].pop_front();
        build(k, d, len, v);
        if (cap_len[k] != len) begin
            failures++;
            $display("FAIL frame_len dut%0d data=%h got=%0d required=%0d",
                     k, d, cap_len[k], len);
        end
        checks++;
        if (cap[k] !== v) begin
            failures++;
            $display("FAIL frame_bits dut%0d data=%h got=%h required=%h",
                     k, d, cap[k], v);
        end
        checks++;
        if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0) begin
            failures++;
            $display("FAIL done_cycle dut%0d tx=%b busy=%b required tx=1 busy=0",
                     k, tx_w[k], busy_w[k]);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (prev_rst && !rst) begin
                checks++;
                if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state dut%0d tx=%b busy=%b done=%b required 1/0/0",
                             k, tx_w[k], busy_w[k], done_w[k]);
                end
            end
            if (busy_w[k] === 1'b1) begin
                if (cap_len[k] < 64) cap[k][cap_len[k]] = tx_w[k];
                cap_len[k]++;
            end
            if (done_w[k] === 1'b1) begin
                check_frame(k);
                cap[k] = '0;
                cap_len[k] = 0;
            end
            if (rst) begin
                cap[k] = '0;
                cap_len[k] = 0;
            end
        end
        prev_rst = rst;
    end

    // One clock cycle: drive, check read-back, then advance the model.
    task automatic step(input bit r, input bit rw, input bit [1:0] cl,
                        input bit [3:0] act, input bit [7:0] wd);
        rst = r;
        row = rw;
        col = cl;
        action = act;
        w_data = wd;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (tc_w[k] !== mcell[rw][cl]) begin
                failures++;
                $display("FAIL t_cell dut%0d [%0d][%0d] got=%h required=%h",
                         k, rw, cl, tc_w[k], mcell[rw][cl]);
            end
        end
        #1;
        if (r) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 4; j++) mcell[i][j] = 8'h00;
            for (int k = 0; k < N; k++) begin
                exp_q[k].delete();
                free_at[k] = cyc + 1;
            end
        end else if (act == ACT_WRITE) begin
            mcell[rw][cl] = wd;
        end else if (act == ACT_SEND) begin
            for (int k = 0; k < N; k++) begin
                if (cyc >= free_at[k]) begin
                    exp_q[k].push_back(mcell[rw][cl]);
                    free_at[k] = cyc + flen(k) + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rw, input bit [1:0] cl);
        for (int i = 0; i < n; i++) step(1'b0, rw, cl, 4'd0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) mcell[i][j] = 8'h00;
        for (int k = 0; k < N; k++) begin
            free_at[k] = 0;
            cap[k] = '0;
            cap_len[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0, 2'd0, 4'd0, 8'h00);

        step(1'b0, 1'b0, 2'd1, ACT_WRITE, 8'hA5);
        idle(1, 1'b0, 2'd1);
        step(1'b0, 1'b0, 2'd1, ACT_SEND, 8'h00);
        idle(9, 1'b0, 2'd1);
        step(1'b0, 1'b1, 2'd2, ACT_SEND, 8'h00);
        step(1'b0, 1'b0, 2'd1, ACT_WRITE, 8'hFF);
        idle(45, 1'b0, 2'd1);

        step(1'b0, 1'b0, 2'd1, ACT_WRITE, 8'hA5);
        step(1'b0, 1'b0, 2'd1, ACT_SEND, 8'h00);
        idle(11, 1'b0, 2'd1);
        step(1'b1, 1'b0, 2'd1, 4'd0, 8'h00);
        step(1'b0, 1'b0, 2'd1, ACT_SEND, 8'h00);
        idle(45, 1'b0, 2'd1);

        step(1'b0, 1'b1, 2'd0, ACT_WRITE, 8'h07);
        step(1'b0, 1'b1, 2'd0, ACT_SEND, 8'h00);
        idle(45, 1'b1, 2'd0);
        step(1'b0, 1'b1, 2'd3, ACT_WRITE, 8'h00);
        step(1'b0, 1'b1, 2'd3, ACT_SEND, 8'h00);
        idle(45, 1'b1, 2'd3);

        for (int i = 0; i < 8; i++)
            step(1'b0, i[2], i[1:0], ACT_WRITE, 8'($urandom));
        for (int i = 0; i < 150; i++)
            step(1'b0, 1'($urandom), 2'($urandom), ACT_SEND, 8'h00);

        for (int i = 0; i < 2500; i++) begin
            int sel;
            bit [3:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 4) a = ACT_WRITE;
            else if (sel < 7) a = ACT_SEND;
            else a = 4'($urandom);
            step(($urandom_range(0, 199) == 0), 1'($urandom), 2'($urandom),
                 a, 8'($urandom));
        end
        idle(60, 1'b0, 2'd0);

        for (int k = 0; k < N; k++) begin
            checks++;
            if (exp_q[k].size() != 0 || cap_len[k] != 0) begin
                failures++;
                $display("FAIL drain dut%0d pending=%0d captured=%0d required 0/0",
                         k, exp_q[k].size(), cap_len[k]);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
